fv_rvc_compressor: RTL
======================

FV_RVC_COMPRESSOR -- requirements
Module: FV_rvc_compressor

Interface
REQ-001 SHALL have parameter COMPRESS, default 1, meaning: 1 = compress eligible instructions; 0 = pass every instruction through as 32 bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning a 32-bit RV32 instruction is offered.
REQ-005 SHALL have port in_instr, input, 32, the offered instruction.
REQ-006 SHALL have port in_ready, output, 1, meaning the instruction is accepted this cycle.
REQ-007 SHALL have port flush, input, 1, a level request to emit any pending halfword.
REQ-008 SHALL have port out_valid, output, 1, meaning out_word is valid.
REQ-009 SHALL have port out_word, output, 32, a packed little-endian word with the lower halfword first.
REQ-010 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-011 SHALL have port half_pending, output, 1, which is 1 when state is HALF.
REQ-012 SHALL have port cnt_total, output, 16, the count of accepted instructions, wrapping.
REQ-013 SHALL have port cnt_compressed, output, 16, the count of accepted instructions that were compressed, wrapping.

Function
REQ-014 SHALL compute in_ready = !out_valid || out_ready; a transfer occurs on in_valid && in_ready.
REQ-015 SHALL register the output: out_valid and out_word SHALL stay stable while out_valid && !out_ready.
REQ-016 SHALL keep a 2-state packer (EMPTY, HALF) with a 16-bit hold register.
REQ-017 On an accepted compressed c in EMPTY, SHALL set hold=c, go to HALF, and emit no word.
REQ-018 On an accepted uncompressed w in EMPTY, SHALL emit w next cycle and stay in EMPTY.
REQ-019 On an accepted compressed c in HALF, SHALL emit {c,hold} and go to EMPTY.
REQ-020 On an accepted uncompressed w in HALF, SHALL emit {w[15:0],hold}, set hold=w[31:16], and stay in HALF.
REQ-021 With flush=1, in_valid=0, state HALF and in_ready=1, SHALL emit {16'h0001 (C.NOP),hold} and go to EMPTY.
- flush in EMPTY SHALL do nothing.
- flush with in_valid=1 SHALL be deferred; the instruction is processed first.
REQ-022 Compression rules, evaluated in the order listed; x8–x15 are encoded as a 3-bit r' = reg-8:
- ADDI with rs1=x0, rd≠0, imm in [-32,31] -> C.LI {010,imm[5],rd,imm[4:0],01}.
- ADDI with imm=0, rd≠0, rs1≠0 -> C.MV {1000,rd,rs1,10}.
- ADDI with rd=rs1≠0, imm≠0, imm in [-32,31] -> C.ADDI {000,imm[5],rd,imm[4:0],01}.
- ADD with rs1=x0, rd≠0, rs2≠0 -> C.MV {1000,rd,rs2,10}.
- ADD with rd=rs1≠0, rs2≠0 -> C.ADD {1001,rd,rs2,10}.
- SUB/XOR/OR/AND with rd=rs1 in x8–x15 and rs2 in x8–x15 -> {100011,rd',f2,rs2',01}, where f2 is 00/01/10/11 respectively.
- SLLI with rd=rs1≠0, shamt 1..31 -> {0000,rd,shamt[4:0],10}.
- LW with rd and rs1 in x8–x15, off%4=0, off in 0..124 -> {010,off[5:3],rs1',off[2],off[6],rd',00}.
- SW with the same constraints (rs2 in place of rd) -> {110,off[5:3],rs1',off[2],off[6],rs2',00}.
- JALR with imm=0, rs1≠0: rd=x0 -> C.JR {1000,rs1,00000,10}; rd=x1 -> C.JALR {1001,rs1,00000,10}.
- EBREAK (0x00100073) -> 0x9002.
- Anything else, including in_instr[1:0]≠11, SHALL be treated as uncompressed and passed unchanged.
REQ-023 With COMPRESS=0, SHALL treat every instruction as uncompressed.
REQ-024 SHALL increment cnt_total on each accept; cnt_compressed SHALL increment when the accepted instruction is compressed; both SHALL wrap from 0xFFFF to 0.
REQ-025 Latency SHALL be one cycle from accept (or flush) to out_valid.

Reset
REQ-026 While reset=1, SHALL set out_valid=0, out_word=0, state=EMPTY, hold=0, cnt_total=0 and cnt_compressed=0; any pending halfword is discarded.
REQ-027 While reset=1, in_ready SHALL be 0.

Verification
REQ-028 Bench SHALL drive 0x00140413 (addi x8,x8,1) then 0x00B50533 (add x10,x10,x11) -> a single out_word 0x952E0405, cnt_compressed=2.
REQ-029 Bench SHALL drive 0x123452B7 in EMPTY -> out_word 0x123452B7 one cycle later, half_pending=0.
REQ-030 Bench SHALL drive 0x00140413 then 0x123452B7 -> out_word 0x52B70405, then half_pending=1 with hold 0x1234; then flush -> out_word 0x00011234.
REQ-031 Bench SHALL hold out_ready=0 with a word pending -> out_word stable, in_ready=0, no accept, counters frozen.
REQ-032 Bench SHALL assert reset while HALF with hold 0x0405 -> out_valid=0, half_pending=0, counters 0; a later flush emits nothing.
REQ-033 Bench SHALL drive 0xFFF00413 (addi x8,x0,-1) with COMPRESS=1 -> 0x547D held; the same input with COMPRESS=0 -> out_word 0xFFF00413.

Source files
------------

// File: rtl/fv_rvc_compressor.sv
// RV32 -> RVC compressor and halfword packer: eligible instructions shrink to 16 bits
// and are packed two halfwords per 32-bit output word, lower halfword first.
module fv_rvc_compressor #(
  parameter int COMPRESS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_word,
  input  logic        out_ready,
  output logic        half_pending,
  output logic [15:0] cnt_total,
  output logic [15:0] cnt_compressed
);

  typedef enum logic {EMPTY, HALF} state_t;

  // Returns {eligible, encoding}; eligible=0 means pass the instruction through as 32 bits.
  function automatic logic [16:0] compress16(input logic [31:0] i);
    logic [16:0] r;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm_i, imm_s;
    logic        imm_fit, rd_c, rs1_c, rs2_c;
    r       = '0;
    op      = i[6:0];
    rd      = i[11:7];
    f3      = i[14:12];
    rs1     = i[19:15];
    rs2     = i[24:20];
    f7      = i[31:25];
    imm_i   = i[31:20];
    imm_s   = {i[31:25], i[11:7]};
    imm_fit = (i[31:25] == {7{i[25]}});
    rd_c    = (rd[4:3] == 2'b01);
    rs1_c   = (rs1[4:3] == 2'b01);
    rs2_c   = (rs2[4:3] == 2'b01);
    if (op == 7'b0010011 && f3 == 3'b000) begin
      if (rs1 == 5'd0 && rd != 5'd0 && imm_fit)
        r = {1'b1, 3'b010, i[25], rd, i[24:20], 2'b01};
      else if (imm_i == 12'd0 && rd != 5'd0 && rs1 != 5'd0)
        r = {1'b1, 4'b1000, rd, rs1, 2'b10};
      else if (rd == rs1 && rd != 5'd0 && imm_i != 12'd0 && imm_fit)
        r = {1'b1, 3'b000, i[25], rd, i[24:20], 2'b01};
    end else if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'd0) begin
      if (rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0)
        r = {1'b1, 4'b1000, rd, rs2, 2'b10};
      else if (rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
        r = {1'b1, 4'b1001, rd, rs2, 2'b10};
      else if (rd == rs1 && rd_c && rs2_c)
        r = {1'b1, 6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
    end else if (op == 7'b0110011 && rd == rs1 && rd_c && rs2_c) begin
      case ({f7, f3})
        {7'h20, 3'b000}: r = {1'b1, 6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
        {7'h00, 3'b100}: r = {1'b1, 6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
        {7'h00, 3'b110}: r = {1'b1, 6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
        {7'h00, 3'b111}: r = {1'b1, 6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
        default:         r = '0;
      endcase
    end else if (op == 7'b0010011 && f3 == 3'b001 && f7 == 7'd0) begin
      if (rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
        r = {1'b1, 4'b0000, rd, rs2, 2'b10};
    end else if (op == 7'b0000011 && f3 == 3'b010) begin
      if (rd_c && rs1_c && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00)
        r = {1'b1, 3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
    end else if (op == 7'b0100011 && f3 == 3'b010) begin
      if (rs2_c && rs1_c && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00)
        r = {1'b1, 3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
    end else if (op == 7'b1100111 && f3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0) begin
      if (rd == 5'd0)      r = {1'b1, 4'b1000, rs1, 5'd0, 2'b10};
      else if (rd == 5'd1) r = {1'b1, 4'b1001, rs1, 5'd0, 2'b10};
    end else if (i == 32'h0010_0073) begin
      r = {1'b1, 16'h9002};
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        vld_p1;
  logic [31:0] word_p1, word_d;
  logic        emit, accept, do_flush, advance, is_c;
  logic [16:0] comp_p0;

  assign advance  = !vld_p1 || out_ready;
  assign in_ready = !reset && advance;
  assign accept   = in_valid && in_ready;
  assign do_flush = flush && !in_valid && in_ready && (state_q == HALF);
  assign comp_p0  = compress16(in_instr);
  assign is_c     = (COMPRESS != 0) && comp_p0[16];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    emit    = 1'b0;
    word_d  = word_p1;
    if (accept) begin
      if (state_q == EMPTY) begin
        if (is_c) begin
          hold_d  = comp_p0[15:0];
          state_d = HALF;
        end else begin
          emit   = 1'b1;
          word_d = in_instr;
        end
      end else begin
        emit = 1'b1;
        if (is_c) begin
          word_d  = {comp_p0[15:0], hold_q};
          state_d = EMPTY;
        end else begin
          word_d = {in_instr[15:0], hold_q};
          hold_d = in_instr[31:16];
        end
      end
    end else if (do_flush) begin
      emit    = 1'b1;
      word_d  = {16'h0001, hold_q};
      state_d = EMPTY;
    end
  end

  // p0 -> p1: packer state, counters and the registered output word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= EMPTY;
      hold_q         <= '0;
      vld_p1         <= 1'b0;
      word_p1        <= '0;
      cnt_total      <= '0;
      cnt_compressed <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (advance) begin
        vld_p1  <= emit;
        word_p1 <= word_d;
      end
      if (accept) begin
        cnt_total <= cnt_total + 16'd1;
        if (is_c) cnt_compressed <= cnt_compressed + 16'd1;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign out_word     = word_p1;
  assign half_pending = (state_q == HALF);

endmodule
